load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 49 ++++
 rtl/load_store_unit_if.sv | 59 +++++
 rtl/lsu_align.sv | 55 +++++
 rtl/load_store_unit.sv | 109 ++++++++++
 tb/tb_load_store_unit.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM states, access sizes, byte-mask constants
// and small helpers used by both the control FSM and the alignment datapath.
package lsu_types;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'b00,
        SIZE_HALF   = 2'b01,
        SIZE_WORD   = 2'b10,
        SIZE_DOUBLE = 2'b11
    } access_size_t;

    localparam logic [7:0] BE_MASK_BYTE   = 8'h01;
    localparam logic [7:0] BE_MASK_HALF   = 8'h03;
    localparam logic [7:0] BE_MASK_WORD   = 8'h0F;
    localparam logic [7:0] BE_MASK_DOUBLE = 8'hFF;

    // A 32-bit bus has no doubleword access; those codes collapse to a word.
    function automatic access_size_t eff_size(input logic [2:0] funct3, input logic wide_bus);
        access_size_t s;
        s = access_size_t'(funct3[1:0]);
        if (!wide_bus && s == SIZE_DOUBLE) s = SIZE_WORD;
        return s;
    endfunction

    function automatic logic [7:0] size_mask(input access_size_t s);
        case (s)
            SIZE_BYTE: return BE_MASK_BYTE;
            SIZE_HALF: return BE_MASK_HALF;
            SIZE_WORD: return BE_MASK_WORD;
            default:   return BE_MASK_DOUBLE;
        endcase
    endfunction

    function automatic logic is_misaligned(input access_size_t s, input logic [2:0] offset);
        case (s)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return offset[0];
            SIZE_WORD: return |offset[1:0];
            default:   return |offset;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response bus and memory-side bus of the load/store unit.
// The misalign flag exists only when LSU_MISALIGN_TRAP_EN is defined.
interface lsu_req_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_read;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready;
    logic                  stall;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
    logic                  misalign;
`endif

    modport master (
        output req_valid, req_read, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, stall, resp_valid, resp_rdata
`ifdef LSU_MISALIGN_TRAP_EN
        , input misalign
`endif
    );

    modport slave (
        input  req_valid, req_read, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, stall, resp_valid, resp_rdata
`ifdef LSU_MISALIGN_TRAP_EN
        , output misalign
`endif
    );
endinterface

interface lsu_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    mem_read;
    logic                    mem_write;
    logic [ADDR_WIDTH-1:0]   mem_address;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_byte_enable;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_resp;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational alignment datapath: byte enables, store-data lane shift and
// load-data shift plus sign/zero extension.
module lsu_align
    import lsu_types::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int BE_W  = DATA_WIDTH / 8,
    localparam int OFF_W = $clog2(BE_W)
) (
    input  logic [2:0]            funct3,
    input  logic [OFF_W-1:0]      offset,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [BE_W-1:0]       byte_enable,
    output logic [DATA_WIDTH-1:0] store_shifted,
    output logic [DATA_WIDTH-1:0] load_extended
);
    access_size_t          size;
    logic [5:0]            shamt;
    logic [DATA_WIDTH-1:0] load_shifted;
    logic [DATA_WIDTH-1:0] keep_mask;
    logic                  sign_bit;

    assign size  = eff_size(funct3, DATA_WIDTH == 64);
    assign shamt = 6'({offset, 3'b000});

    // Enables that run past the top lane are simply dropped (misaligned access).
    assign byte_enable   = BE_W'(size_mask(size)) << offset;
    assign store_shifted = store_data << shamt;
    assign load_shifted  = load_data >> shamt;

    always_comb begin
        keep_mask = '1;
        sign_bit  = load_shifted[DATA_WIDTH-1];
        case (size)
            SIZE_BYTE: begin
                keep_mask = DATA_WIDTH'(8'hFF);
                sign_bit  = load_shifted[7];
            end
            SIZE_HALF: begin
                keep_mask = DATA_WIDTH'(16'hFFFF);
                sign_bit  = load_shifted[15];
            end
            SIZE_WORD: begin
                keep_mask = DATA_WIDTH'(32'hFFFF_FFFF);
                sign_bit  = load_shifted[31];
            end
            default: ;
        endcase
    end

    assign load_extended = (load_shifted & keep_mask) |
                           ((sign_bit && !funct3[2]) ? ~keep_mask : '0);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op at a time and sequences it onto the memory bus.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned ops instead of issuing them.
//
// state     | meaning
// ST_IDLE   | ready for a new op
// ST_ACCESS | strobes held on the memory bus, waiting for mem_resp
// ST_DONE   | one-cycle completion pulse on resp_valid
module load_store_unit
    import lsu_types::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    lsu_req_if.slave   req_bus,
    lsu_mem_if.master  mem_bus
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BE_W);

    lsu_state_t            state, state_next;
    logic                  accept;
    logic                  trap;
    logic                  op_read_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [BE_W-1:0]       be_calc;
    logic [DATA_WIDTH-1:0] wdata_shifted;
    logic [DATA_WIDTH-1:0] load_ext;

    assign accept = (state == ST_IDLE) && req_bus.req_valid &&
                    (req_bus.req_read || req_bus.req_write);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;

    assign trap = is_misaligned(eff_size(req_bus.req_funct3, DATA_WIDTH == 64),
                                3'(req_bus.req_addr[OFF_W-1:0]));
    assign req_bus.misalign = (state == ST_DONE) && misalign_q;

    always_ff @(posedge clk) begin
        if (rst)         misalign_q <= 1'b0;
        else if (accept) misalign_q <= trap;
    end
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept) state_next = trap ? ST_DONE : ST_ACCESS;
            ST_ACCESS: if (mem_bus.mem_resp) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Request fields are frozen at accept so the bus stays stable through ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_read_q <= 1'b0;
            funct3_q  <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                op_read_q <= req_bus.req_read;
                funct3_q  <= req_bus.req_funct3;
                addr_q    <= req_bus.req_addr;
                wdata_q   <= req_bus.req_wdata;
                rdata_q   <= '0;
            end
            if (state == ST_ACCESS && mem_bus.mem_resp)
                rdata_q <= op_read_q ? load_ext : '0;
        end
    end

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .funct3        (funct3_q),
        .offset        (addr_q[OFF_W-1:0]),
        .store_data    (wdata_q),
        .load_data     (mem_bus.mem_rdata),
        .byte_enable   (be_calc),
        .store_shifted (wdata_shifted),
        .load_extended (load_ext)
    );

    assign req_bus.req_ready  = (state == ST_IDLE);
    assign req_bus.stall      = accept || (state == ST_ACCESS);
    assign req_bus.resp_valid = (state == ST_DONE);
    assign req_bus.resp_rdata = rdata_q;

    assign mem_bus.mem_read        = (state == ST_ACCESS) && op_read_q;
    assign mem_bus.mem_write       = (state == ST_ACCESS) && !op_read_q;
    assign mem_bus.mem_address     = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_bus.mem_wdata       = wdata_shifted;
    assign mem_bus.mem_byte_enable = (state == ST_ACCESS) ? be_calc : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a 32-bit and a 64-bit instance, directed ops,
// a memory agent that checks the bus and a response monitor that checks completions.
module tb_load_store_unit;

    typedef struct { logic is_read; logic [63:0] addr; logic [7:0] be; logic [63:0] wdata; } mem_exp_t;
    typedef struct { logic [63:0] rdata; int stall; logic mis; } resp_exp_t;
    typedef struct { logic [63:0] rdata; int lat; } mem_cfg_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_req_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) rq32 ();
    lsu_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) mb32 ();
    lsu_req_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) rq64 ();
    lsu_mem_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) mb64 ();

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .req_bus(rq32), .mem_bus(mb32));
    load_store_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) u_dut64 (
        .clk(clk), .rst(rst), .req_bus(rq64), .mem_bus(mb64));

    logic        d_valid [2];
    logic        d_read, d_write;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [63:0] d_wdata;
    logic        m_resp  [2];
    logic [63:0] m_rdata [2];
    logic        inject  [2];

    assign rq32.req_valid  = d_valid[0];
    assign rq32.req_read   = d_read;
    assign rq32.req_write  = d_write;
    assign rq32.req_funct3 = d_funct3;
    assign rq32.req_addr   = d_addr;
    assign rq32.req_wdata  = d_wdata[31:0];
    assign mb32.mem_resp   = m_resp[0] | inject[0];
    assign mb32.mem_rdata  = m_rdata[0][31:0];
    assign rq64.req_valid  = d_valid[1];
    assign rq64.req_read   = d_read;
    assign rq64.req_write  = d_write;
    assign rq64.req_funct3 = d_funct3;
    assign rq64.req_addr   = d_addr;
    assign rq64.req_wdata  = d_wdata;
    assign mb64.mem_resp   = m_resp[1] | inject[1];
    assign mb64.mem_rdata  = m_rdata[1];

    logic        s_ready [2], s_stall [2], s_rvalid [2], s_mread [2], s_mwrite [2];
    logic [63:0] s_rdata [2], s_maddr [2], s_mwdata [2];
    logic [7:0]  s_be    [2];

    assign s_ready[0]  = rq32.req_ready;
    assign s_stall[0]  = rq32.stall;
    assign s_rvalid[0] = rq32.resp_valid;
    assign s_rdata[0]  = 64'(rq32.resp_rdata);
    assign s_mread[0]  = mb32.mem_read;
    assign s_mwrite[0] = mb32.mem_write;
    assign s_maddr[0]  = 64'(mb32.mem_address);
    assign s_mwdata[0] = 64'(mb32.mem_wdata);
    assign s_be[0]     = 8'(mb32.mem_byte_enable);
    assign s_ready[1]  = rq64.req_ready;
    assign s_stall[1]  = rq64.stall;
    assign s_rvalid[1] = rq64.resp_valid;
    assign s_rdata[1]  = rq64.resp_rdata;
    assign s_mread[1]  = mb64.mem_read;
    assign s_mwrite[1] = mb64.mem_write;
    assign s_maddr[1]  = 64'(mb64.mem_address);
    assign s_mwdata[1] = mb64.mem_wdata;
    assign s_be[1]     = mb64.mem_byte_enable;

    int n_tests = 0;
    int n_fail  = 0;

    mem_exp_t  mem_q  [2][$];
    resp_exp_t resp_q [2][$];
    mem_cfg_t  cfg_q  [2][$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Memory model: checks every strobe cycle against the expected access and
    // answers lat strobe-cycles after the access starts.
    task automatic mem_agent(input int i);
        int       cnt;
        mem_cfg_t cfg;
        mem_exp_t cur;
        cnt = 0;
        cfg = '{rdata: 64'h0, lat: 1};
        cur = '{is_read: 1'b0, addr: 64'h0, be: 8'h0, wdata: 64'h0};
        forever begin
            @(negedge clk);
            if (rst || !(s_mread[i] || s_mwrite[i])) begin
                cnt        = 0;
                m_resp[i]  = 1'b0;
                m_rdata[i] = 64'h5A5A_A5A5_5A5A_A5A5;
            end else begin
                if (cnt == 0) begin
                    if (cfg_q[i].size() > 0) cfg = cfg_q[i].pop_front();
                    else                     cfg = '{rdata: 64'h0, lat: 1};
                    if (mem_q[i].size() > 0) cur = mem_q[i].pop_front();
                    else                     flag($sformatf("unexpected_strobe dut%0d", i));
                end
                check($sformatf("mem_read dut%0d", i),  s_mread[i],  cur.is_read);
                check($sformatf("mem_write dut%0d", i), s_mwrite[i], !cur.is_read);
                check($sformatf("mem_address dut%0d", i), s_maddr[i], cur.addr);
                check($sformatf("byte_enable dut%0d", i), s_be[i], cur.be);
                if (!cur.is_read) check($sformatf("mem_wdata dut%0d", i), s_mwdata[i], cur.wdata);
                m_resp[i]  = (cnt == cfg.lat - 1);
                m_rdata[i] = m_resp[i] ? cfg.rdata : 64'h5A5A_A5A5_5A5A_A5A5;
                cnt++;
            end
        end
    endtask

    task automatic resp_monitor(input int i);
        int        stall_cnt;
        resp_exp_t e;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                stall_cnt = 0;
            end else if (s_rvalid[i]) begin
                if (resp_q[i].size() == 0) begin
                    flag($sformatf("unexpected_resp_valid dut%0d", i));
                end else begin
                    e = resp_q[i].pop_front();
                    check($sformatf("resp_rdata dut%0d", i), s_rdata[i], e.rdata);
                    check($sformatf("stall_cycles dut%0d", i), 64'(stall_cnt), 64'(e.stall));
                    check($sformatf("stall_in_done dut%0d", i), s_stall[i], 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
                    check($sformatf("misalign dut%0d", i),
                          (i == 0) ? rq32.misalign : rq64.misalign, e.mis);
`endif
                end
                stall_cnt = 0;
            end else if (s_stall[i]) begin
                stall_cnt++;
            end
        end
    endtask

    task automatic wait_ready(input int i);
        int t;
        t = 0;
        while (!s_ready[i] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) flag($sformatf("ready_timeout dut%0d", i));
    endtask

    task automatic issue(input int i, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [63:0] mrdata, input int lat,
                         input logic [31:0] exp_addr, input logic [7:0] exp_be,
                         input logic [63:0] exp_wdata, input logic [63:0] exp_rdata,
                         input bit trap);
        int t;
        if (!trap) begin
            mem_q[i].push_back('{is_read: rd, addr: 64'(exp_addr), be: exp_be, wdata: exp_wdata});
            cfg_q[i].push_back('{rdata: mrdata, lat: lat});
        end
        resp_q[i].push_back('{rdata: trap ? 64'h0 : exp_rdata, stall: trap ? 1 : lat + 1, mis: trap});
        @(negedge clk);
        wait_ready(i);
        d_read     = rd;
        d_write    = wr;
        d_funct3   = f3;
        d_addr     = addr;
        d_wdata    = wdata;
        d_valid[i] = 1'b1;
        @(negedge clk);
        d_valid[i] = 1'b0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        t = 0;
        while (resp_q[i].size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            flag($sformatf("resp_timeout dut%0d addr %h", i, addr));
            resp_q[i].delete();
            mem_q[i].delete();
            cfg_q[i].delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        rst      = 1'b1;
        d_valid  = '{1'b0, 1'b0};
        inject   = '{1'b0, 1'b0};
        m_resp   = '{1'b0, 1'b0};
        m_rdata  = '{64'h0, 64'h0};
        d_read   = 1'b0;
        d_write  = 1'b0;
        d_funct3 = 3'b000;
        d_addr   = 32'h0;
        d_wdata  = 64'h0;
        fork
            mem_agent(0);
            mem_agent(1);
            resp_monitor(0);
            resp_monitor(1);
        join_none

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_req_ready",  s_ready[i],  1'b1);
            check("rst_stall",      s_stall[i],  1'b0);
            check("rst_resp_valid", s_rvalid[i], 1'b0);
            check("rst_mem_read",   s_mread[i],  1'b0);
            check("rst_mem_write",  s_mwrite[i], 1'b0);
            check("rst_resp_rdata", s_rdata[i],  64'h0);
            check("rst_byte_en",    s_be[i],     8'h00);
        end

        // 32-bit bus
        issue(0, 1, 0, 3'b010, 32'h104, 64'hDEAD_BEEF, 64'h0, 2, 32'h104, 8'h0F, 64'hDEAD_BEEF, 64'h0, 0);
        issue(0, 0, 1, 3'b010, 32'h104, 64'hDEAD_BEEF, 64'h0, 2, 32'h104, 8'h0F, 64'hDEAD_BEEF, 64'h0, 0);
        issue(0, 1, 0, 3'b000, 32'h103, 64'h0, 64'h80FF_FFFF, 1, 32'h100, 8'h08, 64'h0, 64'hFFFF_FF80, 0);
        issue(0, 1, 0, 3'b100, 32'h103, 64'h0, 64'h80FF_FFFF, 3, 32'h100, 8'h08, 64'h0, 64'h0000_0080, 0);
        issue(0, 0, 1, 3'b001, 32'h102, 64'h1234, 64'h0, 2, 32'h100, 8'h0C, 64'h1234_0000, 64'h0, 0);
        issue(0, 1, 0, 3'b101, 32'h102, 64'h0, 64'h8001_0000, 1, 32'h100, 8'h0C, 64'h0, 64'h0000_8001, 0);
        issue(0, 1, 0, 3'b010, 32'h200, 64'h0, 64'h8000_0001, 4, 32'h200, 8'h0F, 64'h0, 64'h8000_0001, 0);
        issue(0, 1, 0, 3'b011, 32'h208, 64'h0, 64'hCAFE_F00D, 1, 32'h208, 8'h0F, 64'h0, 64'hCAFE_F00D, 0);
        issue(0, 1, 0, 3'b111, 32'h20C, 64'h0, 64'h8000_0000, 1, 32'h20C, 8'h0F, 64'h0, 64'h8000_0000, 0);
        issue(0, 0, 1, 3'b000, 32'h101, 64'h1234_56AB, 64'h0, 1, 32'h100, 8'h02, 64'h3456_AB00, 64'h0, 0);
        // read wins when both op bits are high
        issue(0, 1, 1, 3'b010, 32'h300, 64'h1111_1111, 64'h0BAD_C0DE, 2, 32'h300, 8'h0F, 64'h0, 64'h0BAD_C0DE, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        issue(0, 1, 0, 3'b001, 32'h101, 64'h0, 64'h0, 1, 32'h100, 8'h00, 64'h0, 64'h0, 1);
        issue(0, 0, 1, 3'b010, 32'h106, 64'hDEAD_BEEF, 64'h0, 1, 32'h104, 8'h00, 64'h0, 64'h0, 1);
`else
        issue(0, 1, 0, 3'b001, 32'h101, 64'h0, 64'h448A_BC11, 2, 32'h100, 8'h06, 64'h0, 64'hFFFF_8ABC, 0);
        issue(0, 0, 1, 3'b010, 32'h106, 64'hDEAD_BEEF, 64'h0, 1, 32'h104, 8'h0C, 64'hBEEF_0000, 64'h0, 0);
`endif

        // valid with no op type is not an op
        @(negedge clk);
        d_valid[0] = 1'b1;
        #1;
        check("noop_stall", s_stall[0], 1'b0);
        @(negedge clk);
        d_valid[0] = 1'b0;
        #1;
        check("noop_ready", s_ready[0], 1'b1);
        check("noop_no_strobe", s_mread[0] | s_mwrite[0], 1'b0);

        // stray mem_resp while idle must not complete anything
        @(negedge clk);
        inject[0] = 1'b1;
        repeat (2) @(negedge clk);
        inject[0] = 1'b0;
        #1;
        check("idle_resp_ignored", s_rvalid[0], 1'b0);

        // reset in the middle of an access
        mem_q[0].push_back('{is_read: 1'b1, addr: 64'h400, be: 8'h0F, wdata: 64'h0});
        cfg_q[0].push_back('{rdata: 64'h7777_7777, lat: 20});
        @(negedge clk);
        wait_ready(0);
        d_read     = 1'b1;
        d_funct3   = 3'b010;
        d_addr     = 32'h400;
        d_valid[0] = 1'b1;
        @(negedge clk);
        d_valid[0] = 1'b0;
        d_read     = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        inject[0] = 1'b1;
        @(negedge clk);
        inject[0] = 1'b0;
        #1;
        check("rst_mid_mem_read",  s_mread[0],  1'b0);
        check("rst_mid_mem_write", s_mwrite[0], 1'b0);
        check("rst_mid_ready",     s_ready[0],  1'b1);
        check("rst_mid_resp_valid", s_rvalid[0], 1'b0);
        check("rst_mid_access_seen", 64'(mem_q[0].size()), 64'h0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_mid_still_idle", s_ready[0], 1'b1);
        issue(0, 1, 0, 3'b010, 32'h104, 64'h0, 64'h1234_5678, 1, 32'h104, 8'h0F, 64'h0, 64'h1234_5678, 0);

        // 64-bit bus
        issue(1, 1, 0, 3'b011, 32'h08, 64'h0, 64'h8123_4567_89AB_CDEF, 2, 32'h08, 8'hFF, 64'h0, 64'h8123_4567_89AB_CDEF, 0);
        issue(1, 1, 0, 3'b110, 32'h0C, 64'h0, 64'hF000_0000_1234_5678, 1, 32'h08, 8'hF0, 64'h0, 64'h0000_0000_F000_0000, 0);
        issue(1, 1, 0, 3'b010, 32'h0C, 64'h0, 64'hF000_0000_1234_5678, 1, 32'h08, 8'hF0, 64'h0, 64'hFFFF_FFFF_F000_0000, 0);
        issue(1, 0, 1, 3'b011, 32'h10, 64'h0123_4567_89AB_CDEF, 64'h0, 1, 32'h10, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 0);
        issue(1, 0, 1, 3'b000, 32'h17, 64'h5A, 64'h0, 1, 32'h10, 8'h80, 64'h5A00_0000_0000_0000, 64'h0, 0);
        issue(1, 1, 0, 3'b001, 32'h16, 64'h0, 64'h8001_0000_0000_0000, 3, 32'h10, 8'hC0, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
